stack_guard_unit: RTL and testbench

Parametrised stack-protection unit for the single-cycle datapath, replacing the hard-wired single-stack check on registers 12/13/14 with `NUM_STACKS` independently configured stack regions. It checks every data-memory access against each region's bounds, masks the access in the same cycle when it targets a corrupted stack, and raises a held trap request with captured fault information until software acknowledges it. It sits between the ALU address output (`sum`) and the data-memory/register-file write enables.

---
 rtl/stack_guard_pkg.sv | 16 +
 rtl/stack_region_check.sv | 25 ++
 rtl/stack_guard_unit.sv | 163 ++++++++++++++++
 tb/tb_stack_guard_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_guard_pkg.sv
// rtl/stack_guard_pkg.sv - shared encodings and FSM state type for the stack guard
package stack_guard_pkg;

  localparam logic [1:0] CFG_BASE  = 2'd0;
  localparam logic [1:0] CFG_LIMIT = 2'd1;
  localparam logic [1:0] CFG_SP    = 2'd2;

  localparam logic [1:0] FT_OVF = 2'b01;
  localparam logic [1:0] FT_UNF = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    TRAP = 1'b1
  } state_e;

endpackage

// File: rtl/stack_region_check.sv
// rtl/stack_region_check.sv - combinational bounds/health check for one stack region
module stack_region_check #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] limit_i,
  input  logic [DATA_W-1:0] sp_i,
  input  logic [DATA_W-1:0] addr_i,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              hit_o
);

  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] low;

  assign span = limit_i << 2;
  // An oversized limit would wrap below address 0; pin the region floor at 0 instead.
  assign low  = (span > base_i) ? '0 : (base_i - span);

  assign ovf_o = sp_i > base_i;
  assign unf_o = sp_i < low;
  assign hit_o = (addr_i >= low) && (addr_i <= base_i);

endmodule

// File: rtl/stack_guard_unit.sv
// rtl/stack_guard_unit.sv - multi-region stack guard: config, access masking, trap FSM
module stack_guard_unit
  import stack_guard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_STACKS = 2,
  parameter int SEL_W      = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [1:0]        cfg_field,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              acc_valid,
  input  logic [DATA_W-1:0] acc_addr,
  output logic              acc_allow,
  output logic              trap_req,
  input  logic              trap_ack,
  output logic [DATA_W-1:0] fault_addr,
  output logic [SEL_W-1:0]  fault_stack,
  output logic [1:0]        fault_type,
  output logic              fault_lost,
  output logic [CNT_W-1:0]  fault_count
);

  logic [DATA_W-1:0] base_q  [NUM_STACKS];
  logic [DATA_W-1:0] limit_q [NUM_STACKS];
  logic [DATA_W-1:0] sp_q    [NUM_STACKS];

  logic [NUM_STACKS-1:0] ovf;
  logic [NUM_STACKS-1:0] unf;
  logic [NUM_STACKS-1:0] hit;

  logic              blocked;
  logic [SEL_W-1:0]  sel_idx;
  logic [1:0]        sel_type;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  stack_q, stack_d;
  logic [1:0]        type_q, type_d;
  logic              lost_q, lost_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STACKS; s++) begin
        base_q[s]  <= '0;
        limit_q[s] <= '0;
        sp_q[s]    <= '0;
      end
    end else if (cfg_we) begin
      for (int s = 0; s < NUM_STACKS; s++) begin
        if (cfg_sel == SEL_W'(s)) begin
          case (cfg_field)
            CFG_BASE:  base_q[s]  <= cfg_wdata;
            CFG_LIMIT: limit_q[s] <= cfg_wdata;
            CFG_SP:    sp_q[s]    <= cfg_wdata;
            default:   ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_STACKS; g++) begin : g_region
    stack_region_check #(
      .DATA_W (DATA_W)
    ) u_check (
      .base_i  (base_q[g]),
      .limit_i (limit_q[g]),
      .sp_i    (sp_q[g]),
      .addr_i  (acc_addr),
      .ovf_o   (ovf[g]),
      .unf_o   (unf[g]),
      .hit_o   (hit[g])
    );
  end

  // Scan downwards so the lowest faulting index is the last one written.
  always_comb begin
    blocked  = 1'b0;
    sel_idx  = '0;
    sel_type = '0;
    for (int s = NUM_STACKS - 1; s >= 0; s--) begin
      if (acc_valid && hit[s] && (ovf[s] || unf[s])) begin
        blocked  = 1'b1;
        sel_idx  = SEL_W'(s);
        sel_type = (unf[s] ? FT_UNF : 2'b00) | (ovf[s] ? FT_OVF : 2'b00);
      end
    end
  end

  assign acc_allow = acc_valid && !blocked;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stack_d = stack_q;
    type_d  = type_q;
    lost_d  = lost_q;
    case (state_q)
      IDLE: begin
        if (blocked) begin
          state_d = TRAP;
          addr_d  = acc_addr;
          stack_d = sel_idx;
          type_d  = sel_type;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          if (blocked) begin
            addr_d  = acc_addr;
            stack_d = sel_idx;
            type_d  = sel_type;
          end else begin
            state_d = IDLE;
            lost_d  = 1'b0;
          end
        end else if (blocked) begin
          lost_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (blocked && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      stack_q <= '0;
      type_q  <= '0;
      lost_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stack_q <= stack_d;
      type_q  <= type_d;
      lost_q  <= lost_d;
      count_q <= count_d;
    end
  end

  assign trap_req    = (state_q == TRAP);
  assign fault_addr  = addr_q;
  assign fault_stack = stack_q;
  assign fault_type  = type_q;
  assign fault_lost  = lost_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_stack_guard_unit.sv
// tb/tb_stack_guard_unit.sv - directed self-checking bench for stack_guard_unit
module tb_stack_guard_unit;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [0:0]  cfg_sel;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_wdata;
  logic        acc_valid;
  logic [31:0] acc_addr;
  logic        trap_ack;

  logic        acc_allow, trap_req, fault_lost;
  logic [31:0] fault_addr;
  logic [0:0]  fault_stack;
  logic [1:0]  fault_type;
  logic [7:0]  fault_count;

  logic        acc_allow2, trap_req2, fault_lost2;
  logic [31:0] fault_addr2;
  logic [0:0]  fault_stack2;
  logic [1:0]  fault_type2;
  logic [1:0]  fault_count2;

  int checks;
  int failures;

  stack_guard_unit #(.DATA_W(32), .NUM_STACKS(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .acc_valid(acc_valid),
    .acc_addr(acc_addr), .acc_allow(acc_allow), .trap_req(trap_req),
    .trap_ack(trap_ack), .fault_addr(fault_addr), .fault_stack(fault_stack),
    .fault_type(fault_type), .fault_lost(fault_lost), .fault_count(fault_count)
  );

  stack_guard_unit #(.DATA_W(32), .NUM_STACKS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .acc_valid(acc_valid),
    .acc_addr(acc_addr), .acc_allow(acc_allow2), .trap_req(trap_req2),
    .trap_ack(trap_ack), .fault_addr(fault_addr2), .fault_stack(fault_stack2),
    .fault_type(fault_type2), .fault_lost(fault_lost2), .fault_count(fault_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [0:0] sel, input logic [1:0] field, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_field = field;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_field = '0; cfg_wdata = '0;
    acc_valid = 1'b0; acc_addr = '0; trap_ack = 1'b0;
    repeat (2) step();
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL reset_trap_req got=%b exp=0", trap_req); end
    checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fault_count); end
    checks++; if ({fault_addr, fault_stack, fault_type, fault_lost} !== '0) begin failures++; $display("FAIL reset_fields got=%h/%b/%b/%b exp=0", fault_addr, fault_stack, fault_type, fault_lost); end
    rst_n = 1'b1;
    step();
    acc_valid = 1'b1; acc_addr = 32'h0;
    #1;
    checks++; if (acc_allow !== 1'b1) begin failures++; $display("FAIL reset_allow_zero_cfg got=%b exp=1", acc_allow); end
    step();
    acc_valid = 1'b0;
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL reset_no_trap got=%b exp=0", trap_req); end
  endtask

  task automatic test_allow();
    cfg_write(1'b0, 2'd0, 32'h3C);
    cfg_write(1'b0, 2'd1, 32'd4);
    cfg_write(1'b0, 2'd2, 32'h30);
    acc_valid = 1'b1; acc_addr = 32'h34;
    #1;
    checks++; if (acc_allow !== 1'b1) begin failures++; $display("FAIL allow_healthy got=%b exp=1", acc_allow); end
    step();
    acc_valid = 1'b0;
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL allow_no_trap got=%b exp=0", trap_req); end
  endtask

  task automatic test_overflow();
    cfg_write(1'b0, 2'd2, 32'h40);
    acc_valid = 1'b1; acc_addr = 32'h38;
    #1;
    checks++; if (acc_allow !== 1'b0) begin failures++; $display("FAIL ovf_block got=%b exp=0", acc_allow); end
    step();
    acc_valid = 1'b0;
    checks++; if (trap_req !== 1'b1) begin failures++; $display("FAIL ovf_trap got=%b exp=1", trap_req); end
    checks++; if (fault_addr !== 32'h38) begin failures++; $display("FAIL ovf_addr got=%h exp=38", fault_addr); end
    checks++; if (fault_type !== 2'b01) begin failures++; $display("FAIL ovf_type got=%b exp=01", fault_type); end
    checks++; if (fault_stack !== 1'b0) begin failures++; $display("FAIL ovf_stack got=%b exp=0", fault_stack); end
    checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", fault_count); end
  endtask

  task automatic test_lost();
    acc_valid = 1'b1; acc_addr = 32'h30;
    step();
    acc_valid = 1'b0;
    checks++; if (fault_lost !== 1'b1) begin failures++; $display("FAIL lost_set got=%b exp=1", fault_lost); end
    checks++; if (fault_addr !== 32'h38) begin failures++; $display("FAIL lost_addr_held got=%h exp=38", fault_addr); end
    checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL lost_count got=%0d exp=2", fault_count); end
    trap_ack = 1'b1;
    step();
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL ack_idle got=%b exp=0", trap_req); end
    checks++; if (fault_lost !== 1'b0) begin failures++; $display("FAIL ack_lost_clr got=%b exp=0", fault_lost); end
    step();
    trap_ack = 1'b0;
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL ack_in_idle got=%b exp=0", trap_req); end
  endtask

  task automatic test_priority();
    cfg_write(1'b0, 2'd0, 32'h20);
    cfg_write(1'b0, 2'd1, 32'd4);
    cfg_write(1'b0, 2'd2, 32'h40);
    cfg_write(1'b1, 2'd0, 32'h28);
    cfg_write(1'b1, 2'd1, 32'd4);
    cfg_write(1'b1, 2'd2, 32'h0);
    acc_valid = 1'b1; acc_addr = 32'h20;
    step();
    checks++; if (fault_stack !== 1'b0) begin failures++; $display("FAIL prio_stack got=%b exp=0", fault_stack); end
    checks++; if (fault_count !== 8'd3) begin failures++; $display("FAIL prio_count got=%0d exp=3", fault_count); end
    trap_ack = 1'b1; acc_addr = 32'h28;
    step();
    trap_ack = 1'b0; acc_valid = 1'b0;
    checks++; if (trap_req !== 1'b1) begin failures++; $display("FAIL ackfault_stay got=%b exp=1", trap_req); end
    checks++; if (fault_stack !== 1'b1) begin failures++; $display("FAIL ackfault_stack got=%b exp=1", fault_stack); end
    checks++; if (fault_type !== 2'b10) begin failures++; $display("FAIL ackfault_type got=%b exp=10", fault_type); end
    checks++; if (fault_addr !== 32'h28) begin failures++; $display("FAIL ackfault_addr got=%h exp=28", fault_addr); end
    checks++; if (fault_lost !== 1'b0) begin failures++; $display("FAIL ackfault_lost got=%b exp=0", fault_lost); end
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    cfg_write(1'b1, 2'd2, 32'h20);
    acc_valid = 1'b1; acc_addr = 32'h24;
    #1;
    checks++; if (acc_allow !== 1'b1) begin failures++; $display("FAIL healthy_hit_allow got=%b exp=1", acc_allow); end
    step();
    acc_valid = 1'b0;
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL healthy_hit_trap got=%b exp=0", trap_req); end
  endtask

  task automatic test_clamp();
    cfg_write(1'b0, 2'd0, 32'h8);
    cfg_write(1'b0, 2'd1, 32'd16);
    cfg_write(1'b0, 2'd2, 32'h4);
    acc_valid = 1'b1; acc_addr = 32'h0;
    #1;
    checks++; if (acc_allow !== 1'b1) begin failures++; $display("FAIL clamp_allow got=%b exp=1", acc_allow); end
    step();
    acc_valid = 1'b0;
    cfg_write(1'b0, 2'd2, 32'hC);
    acc_valid = 1'b1; acc_addr = 32'h0;
    #1;
    checks++; if (acc_allow !== 1'b0) begin failures++; $display("FAIL clamp_hit_block got=%b exp=0", acc_allow); end
    step();
    acc_valid = 1'b0;
    checks++; if (fault_count !== 8'd5) begin failures++; $display("FAIL clamp_count got=%0d exp=5", fault_count); end
    checks++; if (fault_count2 !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", fault_count2); end
  endtask

  task automatic test_back_to_back();
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_field = 2'd2; cfg_wdata = 32'h4;
    trap_ack = 1'b1; acc_valid = 1'b1; acc_addr = 32'h0;
    #1;
    checks++; if (acc_allow !== 1'b0) begin failures++; $display("FAIL cfg_old_value got=%b exp=0", acc_allow); end
    step();
    cfg_we = 1'b0; trap_ack = 1'b0;
    #1;
    checks++; if (acc_allow !== 1'b1) begin failures++; $display("FAIL cfg_new_value got=%b exp=1", acc_allow); end
    checks++; if (trap_req !== 1'b1) begin failures++; $display("FAIL b2b_trap got=%b exp=1", trap_req); end
    checks++; if (fault_count !== 8'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", fault_count); end
    checks++; if (fault_count2 !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", fault_count2); end
    step();
    acc_valid = 1'b0;
  endtask

  task automatic test_reset_mid_trap();
    cfg_write(1'b0, 2'd2, 32'hC);
    acc_valid = 1'b1; acc_addr = 32'h0;
    step();
    checks++; if (trap_req !== 1'b1) begin failures++; $display("FAIL mid_trap_enter got=%b exp=1", trap_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (trap_req !== 1'b0) begin failures++; $display("FAIL mid_reset_trap got=%b exp=0", trap_req); end
    checks++; if ({fault_addr, fault_stack, fault_type, fault_lost, fault_count} !== '0) begin failures++; $display("FAIL mid_reset_fields got=%h/%b/%b/%b/%0d exp=0", fault_addr, fault_stack, fault_type, fault_lost, fault_count); end
    checks++; if (acc_allow !== 1'b1) begin failures++; $display("FAIL mid_reset_cfg_clr got=%b exp=1", acc_allow); end
    step();
    rst_n = 1'b1; acc_valid = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_allow();
    test_overflow();
    test_lost();
    test_priority();
    test_clamp();
    test_back_to_back();
    test_reset_mid_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
